gray_counter_n: RTL and testbench
=================================

GRAY_COUNTER_N -- requirements
Module: gray_counter_n

Interface
REQ-001 SHALL have parameter WIDTH, default 3, counter width in bits; legal range 2..32.
REQ-002 SHALL have port Clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-003 SHALL have port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port En, input, 1 bit: count enable.
REQ-005 SHALL have port Dir, input, 1 bit: count direction; 1 = up, 0 = down.
REQ-006 SHALL have port Load, input, 1 bit: synchronous load strobe.
REQ-007 SHALL have port LoadVal, input, WIDTH bits: binary-encoded value to load.
REQ-008 SHALL have port Output, output, WIDTH bits: registered Gray-coded count.
REQ-009 SHALL have port Overflow, output, 1 bit: sticky wrap/limit flag, registered.

Function
REQ-010 SHALL hold the count internally as a WIDTH-bit binary register B; Output SHALL equal B ^ (B >> 1), registered with no combinational path from any input.
REQ-011 On a Clk edge with Load=1, SHALL set B = LoadVal and clear Overflow, regardless of En and Dir (Load has priority).
REQ-012 On a Clk edge with Load=0, En=1, Dir=1, SHALL set B = B+1 modulo 2^WIDTH.
REQ-013 On a Clk edge with Load=0, En=1, Dir=0, SHALL set B = B-1 modulo 2^WIDTH.
REQ-014 On a Clk edge with Load=0 and En=0, SHALL hold B and Overflow.
REQ-015 SHALL set Overflow on the same edge where B wraps: up from 2^WIDTH-1 to 0, or down from 0 to 2^WIDTH-1.
REQ-016 Once set, Overflow SHALL stay 1 until Reset or Load; further wraps SHALL leave it at 1.
REQ-017 Dir SHALL be sampled per edge; a direction change takes effect on the next enabled edge with no idle cycle.
REQ-018 Latency SHALL be one edge from input sample to Output/Overflow update.
REQ-019 Output SHALL change exactly one bit per counting step, including across the wrap.

Reset
REQ-020 Reset=1 SHALL immediately force B=0, Output=0 and Overflow=0, independent of Clk.
REQ-021 While Reset=1, Load and En SHALL be ignored; counting SHALL resume on the first rising Clk edge after Reset deasserts.
REQ-022 Reset asserted mid-count SHALL discard the count and Overflow with no residual state.

Configuration
REQ-023 When macro GRAY_SATURATE_EN is defined, the counter SHALL NOT wrap: up at 2^WIDTH-1 and down at 0 SHALL hold B and set Overflow.
REQ-024 When GRAY_SATURATE_EN is undefined, the counter SHALL wrap per REQ-012, REQ-013 and REQ-015.
REQ-025 The port list SHALL be identical with and without GRAY_SATURATE_EN.

Structure
REQ-026 Package gray_pkg SHALL hold the WIDTH bounds constants (GRAY_WIDTH_MIN=2, GRAY_WIDTH_MAX=32) and the direction constants DIR_UP=1 and DIR_DOWN=0.
REQ-027 SHALL instantiate one combinational sub-module gray_bin2gray (parameter WIDTH) for the binary-to-Gray conversion feeding the Output register.
REQ-028 Wrap/limit detection SHALL use explicit all-ones/all-zeros compares on B.

Verification (WIDTH=3 unless stated)
REQ-029 Assert Reset asynchronously between edges during counting -> Output=000 and Overflow=0 before the next edge.
REQ-030 Reset released, En=1, Dir=1 for 8 edges -> Output 001,011,010,110,111,101,100,000; Overflow=1 on the 8th edge and stays 1.
REQ-031 From 000 with En=1 and Dir=0, one edge -> Output=100 and Overflow=1; with En=0 for 5 edges -> Output and Overflow unchanged.
REQ-032 Load=1, LoadVal=5, En=1 on the same edge with Overflow=1 -> Output=111 and Overflow=0.
REQ-033 GRAY_SATURATE_EN defined, count up to 100 (binary 7), En=1 for 3 more edges -> Output stays 100 and Overflow=1; Dir=0 on the next edge -> Output=101.
REQ-034 WIDTH=4, full up-cycle of 16 edges -> every step changes exactly one Output bit, and Overflow=1 after edge 16.

Source files
------------

// File: rtl/gray_pkg.sv
// ----------------------------------------------------------------------------
// gray_pkg
// Shared constants for the Gray-code counter slice.
//   GRAY_WIDTH_MIN / GRAY_WIDTH_MAX : legal range of the WIDTH parameter
//   DIR_UP / DIR_DOWN               : encoding of the Dir input
// ----------------------------------------------------------------------------
package gray_pkg;

    localparam int GRAY_WIDTH_MIN = 2;
    localparam int GRAY_WIDTH_MAX = 32;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage : gray_pkg

// File: rtl/gray_bin2gray.sv
// ----------------------------------------------------------------------------
// gray_bin2gray
// Purely combinational binary-to-Gray converter.
// Parameters:
//   WIDTH : vector width in bits
// Ports:
//   bin  : input,  WIDTH bits, binary value
//   gray : output, WIDTH bits, reflected-binary Gray code of bin
// ----------------------------------------------------------------------------
module gray_bin2gray #(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray
);

    // Each Gray bit is the XOR of adjacent binary bits; the MSB passes through.
    assign gray = bin ^ (bin >> 1);

endmodule : gray_bin2gray

// File: rtl/gray_counter_n.sv
// ----------------------------------------------------------------------------
// gray_counter_n
// Up/down counter with a binary state register and a registered Gray-coded
// output. A sticky Overflow flag records any wrap (or limit hit when
// saturating) until the next Reset or Load.
//
// Build option:
//   GRAY_SATURATE_EN : when defined, the count holds at all-ones (up) and at
//                      zero (down) instead of wrapping; Overflow still sets.
//                      The port list is the same in both builds.
//
// Parameters:
//   WIDTH : counter width in bits, legal range 2..32
// Ports:
//   Clk      : input,  rising-edge clock
//   Reset    : input,  asynchronous active-high reset
//   En       : input,  count enable
//   Dir      : input,  direction, 1 = up, 0 = down
//   Load     : input,  synchronous load strobe, priority over En/Dir
//   LoadVal  : input,  WIDTH bits, binary value to load
//   Output   : output, WIDTH bits, registered Gray-coded count
//   Overflow : output, registered sticky wrap/limit flag
// ----------------------------------------------------------------------------
module gray_counter_n
    import gray_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             En,
    input  logic             Dir,
    input  logic             Load,
    input  logic [WIDTH-1:0] LoadVal,
    output logic [WIDTH-1:0] Output,
    output logic             Overflow
);

    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ALL_ZERO = {WIDTH{1'b0}};

    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] b_next;
    logic [WIDTH-1:0] gray_next;
    logic             ovf_next;
    logic             at_max;
    logic             at_min;

    // Limit detection is done on the current binary state, not on the
    // incremented value, so no carry-out bit is needed.
    assign at_max = (b_q == ALL_ONES);
    assign at_min = (b_q == ALL_ZERO);

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        b_next   = b_q;
        ovf_next = Overflow;
        if (Load) begin
            b_next   = LoadVal;
            ovf_next = 1'b0;
        end else if (En) begin
            if (Dir == DIR_UP) begin
                if (at_max) begin
                    ovf_next = 1'b1;
`ifdef GRAY_SATURATE_EN
                    b_next   = b_q;
`else
                    b_next   = ALL_ZERO;
`endif
                end else begin
                    b_next = b_q + ONE;
                end
            end else begin
                if (at_min) begin
                    ovf_next = 1'b1;
`ifdef GRAY_SATURATE_EN
                    b_next   = b_q;
`else
                    b_next   = ALL_ONES;
`endif
                end else begin
                    b_next = b_q - ONE;
                end
            end
        end
    end

    // Convert the next binary state so Output is a plain register that always
    // matches the Gray code of b_q, with no logic after the flop.
    gray_bin2gray #(
        .WIDTH (WIDTH)
    ) u_bin2gray (
        .bin  (b_next),
        .gray (gray_next)
    );

    // NOTE: sequential state uses non-blocking assignments so all three
    // registers update together from values sampled before the edge.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            b_q      <= ALL_ZERO;
            Output   <= ALL_ZERO;
            Overflow <= 1'b0;
        end else begin
            b_q      <= b_next;
            Output   <= gray_next;
            Overflow <= ovf_next;
        end
    end

endmodule : gray_counter_n

// File: tb/tb_gray_counter_n.sv
// ----------------------------------------------------------------------------
// tb_gray_counter_n
// Self-checking bench for gray_counter_n. A WIDTH=3 instance is exercised by
// directed and random scenarios against an integer reference model; a WIDTH=4
// instance covers a full up-cycle. Define GRAY_SATURATE_EN to check the
// saturating build.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_gray_counter_n;
    import gray_pkg::*;

    localparam int MAX3 = 7;
    localparam int MOD4 = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       en3, dir3, load3;
    logic [2:0] lv3;
    logic [2:0] out3;
    logic       ovf3;
    logic       en4, dir4, load4;
    logic [3:0] lv4;
    logic [3:0] out4;
    logic       ovf4;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model of the WIDTH=3 counter: plain integer count + flag.
    int m3;
    bit o3;

    always #5 clk = ~clk;

    gray_counter_n #(.WIDTH(3)) u_dut3 (
        .Clk(clk), .Reset(rst), .En(en3), .Dir(dir3), .Load(load3),
        .LoadVal(lv3), .Output(out3), .Overflow(ovf3)
    );

    gray_counter_n #(.WIDTH(4)) u_dut4 (
        .Clk(clk), .Reset(rst), .En(en4), .Dir(dir4), .Load(load4),
        .LoadVal(lv4), .Output(out4), .Overflow(ovf4)
    );

    function automatic int gray_of(input int v);
        return v ^ (v >> 1);
    endfunction

    task automatic model3(input bit load, input int lv, input bit en, input bit dir);
        int nxt;
        if (load) begin
            m3 = lv;
            o3 = 1'b0;
        end else if (en) begin
            nxt = dir ? m3 + 1 : m3 - 1;
            if (nxt > MAX3 || nxt < 0) begin
                o3 = 1'b1;
`ifndef GRAY_SATURATE_EN
                m3 = (nxt + MAX3 + 1) % (MAX3 + 1);
`endif
            end else begin
                m3 = nxt;
            end
        end
    endtask

    // Apply one set of inputs, let one rising edge pass, sample 1 ns later.
    task automatic step3(input bit load, input int lv, input bit en, input bit dir);
        load3 = load;
        lv3   = lv[2:0];
        en3   = en;
        dir3  = dir;
        @(posedge clk);
        #1;
        model3(load, lv, en, dir);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        en3 = 1'b0; dir3 = 1'b0; load3 = 1'b0; lv3 = '0;
        en4 = 1'b0; dir4 = 1'b0; load4 = 1'b0; lv4 = '0;
        #2;
        vectors++;
        if (out3 !== 3'b000 || ovf3 !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_w3: out=%b ovf=%b expected out=000 ovf=0", out3, ovf3);
        end
        vectors++;
        if (out4 !== 4'b0000 || ovf4 !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_w4: out=%b ovf=%b expected out=0000 ovf=0", out4, ovf4);
        end
        // Load and En while Reset is held must be ignored.
        load3 = 1'b1; lv3 = 3'd5; en3 = 1'b1; dir3 = DIR_UP;
        @(posedge clk);
        #1;
        vectors++;
        if (out3 !== 3'b000 || ovf3 !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ignores_load: out=%b ovf=%b expected out=000 ovf=0", out3, ovf3);
        end
        load3 = 1'b0; en3 = 1'b0;
        rst = 1'b0;
        m3 = 0;
        o3 = 1'b0;
    endtask

    task automatic test_up_sequence;
        logic [2:0] exp_seq [8];
        exp_seq = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
`ifdef GRAY_SATURATE_EN
        exp_seq[7] = 3'b100;
`endif
        for (int i = 0; i < 8; i++) begin
            step3(1'b0, 0, 1'b1, DIR_UP);
            vectors++;
            if (out3 !== exp_seq[i] || ovf3 !== (i == 7)) begin
                miscompares++;
                $display("FAIL up_seq[%0d]: out=%b ovf=%b expected out=%b ovf=%0d",
                         i, out3, ovf3, exp_seq[i], (i == 7));
            end
        end
        for (int i = 0; i < 2; i++) begin
            step3(1'b0, 0, 1'b1, DIR_UP);
            vectors++;
            if (out3 !== 3'(gray_of(m3)) || ovf3 !== 1'b1) begin
                miscompares++;
                $display("FAIL up_sticky[%0d]: out=%b ovf=%b expected out=%b ovf=1",
                         i, out3, ovf3, 3'(gray_of(m3)));
            end
        end
    endtask

    task automatic test_down_wrap;
        logic [2:0] exp_out;
        step3(1'b1, 0, 1'b0, DIR_DOWN);
        vectors++;
        if (out3 !== 3'b000 || ovf3 !== 1'b0) begin
            miscompares++;
            $display("FAIL load_zero: out=%b ovf=%b expected out=000 ovf=0", out3, ovf3);
        end
`ifdef GRAY_SATURATE_EN
        exp_out = 3'b000;
`else
        exp_out = 3'b100;
`endif
        step3(1'b0, 0, 1'b1, DIR_DOWN);
        vectors++;
        if (out3 !== exp_out || ovf3 !== 1'b1) begin
            miscompares++;
            $display("FAIL down_wrap: out=%b ovf=%b expected out=%b ovf=1", out3, ovf3, exp_out);
        end
        for (int i = 0; i < 5; i++) begin
            step3(1'b0, $urandom_range(7), 1'b0, 1'($urandom_range(1)));
            vectors++;
            if (out3 !== exp_out || ovf3 !== 1'b1) begin
                miscompares++;
                $display("FAIL hold[%0d]: out=%b ovf=%b expected out=%b ovf=1", i, out3, ovf3, exp_out);
            end
        end
    endtask

    task automatic test_load_priority;
        step3(1'b1, 5, 1'b1, 1'($urandom_range(1)));
        vectors++;
        if (out3 !== 3'b111 || ovf3 !== 1'b0) begin
            miscompares++;
            $display("FAIL load_priority: out=%b ovf=%b expected out=111 ovf=0", out3, ovf3);
        end
    endtask

    task automatic test_async_reset;
        for (int i = 0; i < 9; i++) step3(1'b0, 0, 1'b1, DIR_UP);
        vectors++;
        if (ovf3 !== 1'b1) begin
            miscompares++;
            $display("FAIL pre_reset_ovf: ovf=%b expected 1", ovf3);
        end
        #3;               // mid-cycle, well away from either edge
        rst = 1'b1;
        #1;
        vectors++;
        if (out3 !== 3'b000 || ovf3 !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: out=%b ovf=%b expected out=000 ovf=0", out3, ovf3);
        end
        @(posedge clk);
        #2;
        rst = 1'b0;
        m3 = 0;
        o3 = 1'b0;
        step3(1'b0, 0, 1'b1, DIR_UP);
        vectors++;
        if (out3 !== 3'b001 || ovf3 !== 1'b0) begin
            miscompares++;
            $display("FAIL resume_after_reset: out=%b ovf=%b expected out=001 ovf=0", out3, ovf3);
        end
    endtask

`ifdef GRAY_SATURATE_EN
    task automatic test_saturate;
        step3(1'b1, 7, 1'b0, DIR_UP);
        vectors++;
        if (out3 !== 3'b100 || ovf3 !== 1'b0) begin
            miscompares++;
            $display("FAIL sat_load7: out=%b ovf=%b expected out=100 ovf=0", out3, ovf3);
        end
        for (int i = 0; i < 3; i++) begin
            step3(1'b0, 0, 1'b1, DIR_UP);
            vectors++;
            if (out3 !== 3'b100 || ovf3 !== 1'b1) begin
                miscompares++;
                $display("FAIL sat_hold[%0d]: out=%b ovf=%b expected out=100 ovf=1", i, out3, ovf3);
            end
        end
        step3(1'b0, 0, 1'b1, DIR_DOWN);
        vectors++;
        if (out3 !== 3'b101 || ovf3 !== 1'b1) begin
            miscompares++;
            $display("FAIL sat_down: out=%b ovf=%b expected out=101 ovf=1", out3, ovf3);
        end
    endtask
`endif

    task automatic test_random;
        bit ld, e, d;
        int v;
        for (int i = 0; i < 300; i++) begin
            ld = ($urandom_range(15) == 0);
            e  = ($urandom_range(3) != 0);
            d  = 1'($urandom_range(1));
            v  = $urandom_range(7);
            step3(ld, v, e, d);
            vectors++;
            if (out3 !== 3'(gray_of(m3)) || ovf3 !== o3) begin
                miscompares++;
                $display("FAIL random[%0d]: out=%b ovf=%b expected out=%b ovf=%b",
                         i, out3, ovf3, 3'(gray_of(m3)), o3);
            end
        end
        en3 = 1'b0; load3 = 1'b0;
    endtask

    task automatic test_width4;
        logic [3:0] prev, exp_out;
        int         cnt, exp_bits;
        load4 = 1'b1; lv4 = 4'd0; en4 = 1'b0; dir4 = DIR_UP;
        @(posedge clk);
        #1;
        load4 = 1'b0; en4 = 1'b1;
        prev = out4;
        for (int i = 1; i <= MOD4; i++) begin
            @(posedge clk);
            #1;
`ifdef GRAY_SATURATE_EN
            cnt      = (i < MOD4) ? i : MOD4 - 1;
            exp_bits = (i < MOD4) ? 1 : 0;
`else
            cnt      = i % MOD4;
            exp_bits = 1;
`endif
            exp_out = 4'(gray_of(cnt));
            vectors++;
            if (out4 !== exp_out || $countones(prev ^ out4) != exp_bits || ovf4 !== (i == MOD4)) begin
                miscompares++;
                $display("FAIL w4_step[%0d]: out=%b prev=%b ovf=%b expected out=%b bits_changed=%0d ovf=%0d",
                         i, out4, prev, ovf4, exp_out, exp_bits, (i == MOD4));
            end
            prev = out4;
        end
        en4 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_up_sequence();
        test_down_wrap();
        test_load_priority();
        test_async_reset();
`ifdef GRAY_SATURATE_EN
        test_saturate();
`endif
        test_random();
        test_width4();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_gray_counter_n
